// File: rtl/ble_tx_pkg.sv
// rtl/ble_tx_pkg.sv - shared state encoding, framing constants and length clamp for the BLE TX bit sequencer
package ble_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_PRE  = 3'd1,
        S_AA   = 3'd2,
        S_PDU  = 3'd3,
        S_CRC  = 3'd4,
        S_DONE = 3'd5
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_EVEN    = 8'hAA;
    localparam logic [7:0]  PREAMBLE_ODD     = 8'h55;
    localparam int          PRE_BITS         = 8;
    localparam int          AA_BITS          = 32;
    localparam int          CRC_BITS         = 24;
    localparam logic [23:0] BLE_ADV_CRC_INIT = 24'h555555;
    localparam logic [8:0]  PDU_LEN_MIN      = 9'd2;

    function automatic logic [8:0] clamp_pdu_len(input logic [8:0] len, input logic [8:0] max_len);
        if (len < PDU_LEN_MIN) begin
            return PDU_LEN_MIN;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/ble_tx_bit_fsm_if.sv
// rtl/ble_tx_bit_fsm_if.sv - PDU byte handshake between the byte source and the bit sequencer
interface ble_tx_bit_fsm_if;
    logic [7:0] byte_data;
    logic       byte_vld;
    logic       byte_rdy;

    modport master (output byte_data, output byte_vld, input byte_rdy);
    modport slave  (input byte_data, input byte_vld, output byte_rdy);
endinterface

// File: rtl/ble_bit_shifter.sv
// rtl/ble_bit_shifter.sv - loadable shift register presenting its next bit LSB- or MSB-first
module ble_bit_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    output logic             out_bit
);
    logic [WIDTH-1:0] q;

    // A load takes priority so a new byte can replace the last bit of the previous one
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
        end
    end

    assign out_bit = MSB_FIRST ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/ble_tx_bit_fsm.sv
// rtl/ble_tx_bit_fsm.sv - BLE link-layer TX bit sequencer: preamble, access address, PDU and CRC onto one tick-paced stream
module ble_tx_bit_fsm
    import ble_tx_pkg::*;
#(
    parameter int MAX_PDU_BYTES = 257
) (
    input  logic                    pka_1or2m_gclk,
    input  logic                    r_tx_rst,
    input  logic                    bit_tick,
    input  logic                    tx_start,
    input  logic [31:0]             access_addr,
    input  logic [8:0]              pdu_len,
    ble_tx_bit_fsm_if.slave         byte_if,
    input  logic [23:0]             r_crc_lfsr,
    output logic                    fsm_crc_init,
    output logic                    fsm_switch_crc,
    output logic                    crc_din_vld,
    output logic                    r_fsm_data,
    output logic                    tx_bit,
    output logic                    tx_bit_vld,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    tx_err
);
    localparam int CNT_W = $clog2(MAX_PDU_BYTES + 1);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_PRE  = S_PRE;
    localparam logic [2:0] ST_AA   = S_AA;
    localparam logic [2:0] ST_PDU  = S_PDU;
    localparam logic [2:0] ST_CRC  = S_CRC;
    localparam logic [2:0] ST_DONE = S_DONE;

    logic [2:0]       state;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] len_q;
    logic             data_bit;
    logic             crc_bit;

    logic start_ok, tick_pre, tick_aa, tick_pdu, tick_crc, emit;
    logic last_pre, last_aa, byte_end, last_crc, more_bytes;
    logic byte_take, cur_bit;

    assign start_ok   = tx_start && (state == ST_IDLE);
    assign tick_pre   = bit_tick && (state == ST_PRE);
    assign tick_aa    = bit_tick && (state == ST_AA);
    assign tick_pdu   = bit_tick && (state == ST_PDU);
    assign tick_crc   = bit_tick && (state == ST_CRC);
    assign emit       = tick_pre || tick_aa || tick_pdu || tick_crc;

    assign last_pre   = tick_pre && (bit_cnt == 5'(PRE_BITS - 1));
    assign last_aa    = tick_aa  && (bit_cnt == 5'(AA_BITS - 1));
    assign byte_end   = tick_pdu && (bit_cnt == 5'd7);
    assign last_crc   = tick_crc && (bit_cnt == 5'(CRC_BITS - 1));
    assign more_bytes = (byte_cnt != len_q);

    assign byte_if.byte_rdy = last_aa || (byte_end && more_bytes);
    assign byte_take        = byte_if.byte_rdy && byte_if.byte_vld;

    // The CRC stage has already absorbed the last PDU bit, so its MSB is live on the first CRC tick
    assign cur_bit = (state == ST_CRC) ? ((bit_cnt == 5'd0) ? r_crc_lfsr[23] : crc_bit) : data_bit;

    assign fsm_switch_crc = (state == ST_PDU);
    assign crc_din_vld    = tick_pdu;
    assign r_fsm_data     = data_bit;
    assign tx_busy        = (state != ST_IDLE);

    ble_bit_shifter #(.WIDTH(40), .MSB_FIRST(1'b0)) u_data_sr (
        .clk      (pka_1or2m_gclk),
        .rst      (r_tx_rst),
        .load     (start_ok || byte_take),
        .shift    (tick_pre || tick_aa || tick_pdu),
        .load_val (start_ok ? {access_addr, (access_addr[0] ? PREAMBLE_ODD : PREAMBLE_EVEN)}
                            : {32'd0, byte_if.byte_data}),
        .out_bit  (data_bit)
    );

    ble_bit_shifter #(.WIDTH(24), .MSB_FIRST(1'b1)) u_crc_sr (
        .clk      (pka_1or2m_gclk),
        .rst      (r_tx_rst),
        .load     (tick_crc && (bit_cnt == 5'd0)),
        .shift    (tick_crc),
        .load_val ({r_crc_lfsr[22:0], 1'b0}),
        .out_bit  (crc_bit)
    );

    always_ff @(posedge pka_1or2m_gclk) begin
        if (r_tx_rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            len_q        <= '0;
            fsm_crc_init <= 1'b0;
            tx_bit       <= 1'b0;
            tx_bit_vld   <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            fsm_crc_init <= start_ok;
            tx_bit_vld   <= emit;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
            if (emit) begin
                tx_bit <= cur_bit;
            end
            if (tick_pre || tick_aa || tick_pdu || tick_crc) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        state    <= ST_PRE;
                        len_q    <= CNT_W'(clamp_pdu_len(pdu_len, 9'(MAX_PDU_BYTES)));
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_PRE: begin
                    if (last_pre) begin
                        state   <= ST_AA;
                        bit_cnt <= '0;
                    end
                end
                ST_AA: begin
                    if (last_aa) begin
                        bit_cnt <= '0;
                        if (byte_if.byte_vld) begin
                            state    <= ST_PDU;
                            byte_cnt <= CNT_W'(1);
                        end else begin
                            state  <= ST_IDLE;
                            tx_err <= 1'b1;
                        end
                    end
                end
                ST_PDU: begin
                    if (byte_end) begin
                        bit_cnt <= '0;
                        if (!more_bytes) begin
                            state <= ST_CRC;
                        end else if (byte_if.byte_vld) begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end else begin
                            state  <= ST_IDLE;
                            tx_err <= 1'b1;
                        end
                    end
                end
                ST_CRC: begin
                    if (last_crc) begin
                        state   <= ST_DONE;
                        bit_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    tx_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ble_tx_bit_fsm.sv
// tb/tb_ble_tx_bit_fsm.sv - scoreboard bench for ble_tx_bit_fsm with a CRC-24 stage and byte source model
module tb_ble_tx_bit_fsm;
    import ble_tx_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_tx_rst, bit_tick, tx_start;
    logic [31:0] access_addr;
    logic [8:0]  pdu_len;
    logic [23:0] crc_lfsr;
    logic        fsm_crc_init, fsm_switch_crc, crc_din_vld, r_fsm_data;
    logic        tx_bit, tx_bit_vld, tx_busy, tx_done, tx_err;

    ble_tx_bit_fsm_if byte_if ();

    ble_tx_bit_fsm #(.MAX_PDU_BYTES(257)) dut (
        .pka_1or2m_gclk (clk),
        .r_tx_rst       (r_tx_rst),
        .bit_tick       (bit_tick),
        .tx_start       (tx_start),
        .access_addr    (access_addr),
        .pdu_len        (pdu_len),
        .byte_if        (byte_if.slave),
        .r_crc_lfsr     (crc_lfsr),
        .fsm_crc_init   (fsm_crc_init),
        .fsm_switch_crc (fsm_switch_crc),
        .crc_din_vld    (crc_din_vld),
        .r_fsm_data     (r_fsm_data),
        .tx_bit         (tx_bit),
        .tx_bit_vld     (tx_bit_vld),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_err         (tx_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] crc_step(input logic [23:0] s, input logic d);
        logic fb;
        logic [23:0] n;
        fb = s[23] ^ d;
        n  = {s[22:0], 1'b0};
        if (fb) n = n ^ 24'h00065B;
        return n;
    endfunction

    logic [7:0] pdu_mem [0:511];

    function automatic logic [23:0] ref_crc(input int n);
        logic [23:0] s;
        s = BLE_ADV_CRC_INIT;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                s = crc_step(s, pdu_mem[i][b]);
        return s;
    endfunction

    // CRC-24 stage downstream of the sequencer
    always @(posedge clk) begin
        if (r_tx_rst)          crc_lfsr <= 24'd0;
        else if (fsm_crc_init) crc_lfsr <= BLE_ADV_CRC_INIT;
        else if (crc_din_vld)  crc_lfsr <= crc_step(crc_lfsr, r_fsm_data);
    end

    // Byte source: serves pdu_mem in order, runs dry after src_limit bytes
    int byte_idx  = 0;
    int src_limit = 1000;
    always @(posedge clk) begin
        if (fsm_crc_init)                               byte_idx <= 0;
        else if (byte_if.byte_rdy && byte_if.byte_vld) byte_idx <= byte_idx + 1;
    end
    always_comb begin
        byte_if.byte_data = pdu_mem[byte_idx[8:0]];
        byte_if.byte_vld  = (byte_idx < src_limit);
    end

    int cyc = 0;
    bit tick_en = 1'b0, tick_div = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    assign bit_tick = tick_en && (!tick_div || cyc[0]);

    logic exp_q[$];
    int vld_cnt = 0, din_cnt = 0, done_cnt = 0, err_cnt = 0, init_cnt = 0;
    int last_vld = -1;

    always @(negedge clk) begin
        logic [1:0] e;
        if (tx_bit_vld) begin
            vld_cnt++;
            if (tick_div && last_vld >= 0) chk("vld_gap", 32'(cyc - last_vld), 32'd2);
            last_vld = cyc;
            e = (exp_q.size() == 0) ? 2'b10 : {1'b0, exp_q.pop_front()};
            chk("tx_bit", {31'd0, tx_bit}, {30'd0, e});
        end
        if (crc_din_vld)  din_cnt++;
        if (tx_done)      begin done_cnt++; last_vld = -1; end
        if (tx_err)       begin err_cnt++;  last_vld = -1; end
        if (fsm_crc_init) init_cnt++;
    end

    int s_vld, s_din, s_done, s_err, s_init;
    int pdu_bytes, exp_bits;
    bit pkt_err;

    task automatic push_lsb(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic start_pkt(input logic [31:0] aa, input logic [8:0] len_in, input int nb, input int limit);
        logic [23:0] c;
        exp_q.delete();
        push_lsb(aa[0] ? 32'(PREAMBLE_ODD) : 32'(PREAMBLE_EVEN), 8);
        push_lsb(aa, 32);
        pkt_err   = (limit < nb);
        pdu_bytes = pkt_err ? limit : nb;
        for (int i = 0; i < pdu_bytes; i++) push_lsb(32'(pdu_mem[i]), 8);
        if (!pkt_err) begin
            c = ref_crc(nb);
            for (int i = 23; i >= 0; i--) exp_q.push_back(c[i]);
        end
        exp_bits = 40 + pdu_bytes * 8 + (pkt_err ? 0 : 24);
        s_vld = vld_cnt; s_din = din_cnt; s_done = done_cnt; s_err = err_cnt; s_init = init_cnt;
        src_limit = limit;
        @(posedge clk); #1;
        tx_start = 1'b1; access_addr = aa; pdu_len = len_in;
        @(posedge clk); #1;
        tx_start = 1'b0; access_addr = ~aa; pdu_len = 9'd0;
    endtask

    task automatic finish_pkt(input string name);
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < 20000 && !ended; i++) begin
            @(negedge clk);
            ended = (done_cnt != s_done) || (err_cnt != s_err);
        end
        repeat (4) @(negedge clk);
        chk({name, "_end"},  {31'd0, ended}, 32'd1);
        chk({name, "_vld"},  32'(vld_cnt - s_vld), 32'(exp_bits));
        chk({name, "_din"},  32'(din_cnt - s_din), 32'(pdu_bytes * 8));
        chk({name, "_done"}, 32'(done_cnt - s_done), pkt_err ? 32'd0 : 32'd1);
        chk({name, "_err"},  32'(err_cnt - s_err), pkt_err ? 32'd1 : 32'd0);
        chk({name, "_init"}, 32'(init_cnt - s_init), 32'd1);
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy"}, {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        bit got;
        r_tx_rst = 1'b1; tx_start = 1'b0; access_addr = '0; pdu_len = '0;
        for (int i = 0; i < 512; i++) pdu_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_vld",  {31'd0, tx_bit_vld}, 32'd0);
        chk("rst_bit",  {31'd0, tx_bit}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_err",  {31'd0, tx_err}, 32'd0);
        chk("rst_init", {31'd0, fsm_crc_init}, 32'd0);
        chk("rst_sw",   {31'd0, fsm_switch_crc}, 32'd0);
        @(posedge clk); #1;
        r_tx_rst = 1'b0; tick_en = 1'b1;

        start_pkt(32'h8E89BED6, 9'd2, 2, 1000);
        finish_pkt("adv");

        start_pkt(32'h71764129, 9'd2, 2, 1000);
        finish_pkt("pre55");

        for (int i = 0; i < 4; i++) pdu_mem[i] = 8'(8'h11 * (i + 1));
        start_pkt(32'h8E89BED6, 9'd4, 4, 2);
        finish_pkt("underflow");

        pdu_mem[0] = 8'h00; pdu_mem[1] = 8'h00;
        tick_div = 1'b1;
        start_pkt(32'h8E89BED6, 9'd2, 2, 1000);
        finish_pkt("sparse");
        tick_div = 1'b0;

        for (int i = 0; i < 4; i++) pdu_mem[i] = 8'($urandom);
        start_pkt(32'h12345678, 9'd4, 4, 1000);
        for (int i = 0; i < 200 && (din_cnt - s_din) < 3; i++) @(negedge clk);
        chk("rst_reach_pdu", {31'd0, fsm_switch_crc}, 32'd1);
        @(posedge clk); #1; r_tx_rst = 1'b1;
        @(posedge clk); #1; r_tx_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_rst_vld",  {31'd0, tx_bit_vld}, 32'd0);
        chk("mid_rst_bit",  {31'd0, tx_bit}, 32'd0);
        chk("mid_rst_sw",   {31'd0, fsm_switch_crc}, 32'd0);
        chk("mid_rst_din",  {31'd0, crc_din_vld}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("mid_rst_nodone", 32'(done_cnt - s_done), 32'd0);
        chk("mid_rst_noerr",  32'(err_cnt - s_err), 32'd0);
        pdu_mem[0] = 8'h00; pdu_mem[1] = 8'h00;
        start_pkt(32'h8E89BED6, 9'd2, 2, 1000);
        finish_pkt("restart");

        for (int i = 0; i < 5; i++) pdu_mem[i] = 8'($urandom);
        start_pkt(32'hA5A5F00F, 9'd5, 5, 1000);
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (fsm_switch_crc) got = 1'b1;
        end
        for (int i = 0; i < 5000 && got && fsm_switch_crc; i++) @(negedge clk);
        chk("busy_reach_crc", {31'd0, got && tx_busy && !fsm_switch_crc}, 32'd1);
        @(posedge clk); #1; tx_start = 1'b1; access_addr = 32'h0BADF00D; pdu_len = 9'd3;
        @(posedge clk); #1; tx_start = 1'b0;
        finish_pkt("busy");

        for (int i = 0; i < 257; i++) pdu_mem[i] = 8'($urandom);
        start_pkt(32'h50654B3C, 9'd257, 257, 1000);
        finish_pkt("max");

        start_pkt(32'h50654B3D, 9'd400, 257, 1000);
        finish_pkt("clamp_hi");

        start_pkt(32'h8E89BED6, 9'd1, 2, 1000);
        finish_pkt("clamp_lo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
